// File: rtl/regarb_pkg.sv
// regarb_pkg: shared definitions for the register-file write arbiter.
//   - regarb_state_e : arbiter state encoding (EMPTY / HELD / FORCE)
//   - ZERO_REG       : hard-wired zero register index; writes to it are dropped
//   - WAIT_W         : width of the starvation wait counter
package regarb_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HELD  = 2'd1,
    FORCE = 2'd2
  } regarb_state_e;

  localparam int ZERO_REG = 0;
  localparam int WAIT_W   = 8;

endpackage

// File: rtl/regarb_hold_buf.sv
// regarb_hold_buf: single-entry {addr, data} holding register for a parked
// mult/div result.
//   clock, reset : clock, synchronous active-high reset
//   clr          : synchronous clear (entry consumed or discarded)
//   ld           : load ld_addr/ld_data and mark valid
//   vld          : entry occupied
//   addr, data   : parked destination and value
module regarb_hold_buf #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              ld,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  output logic              vld,
  output logic [ADDR_W-1:0] addr,
  output logic [WIDTH-1:0]  data
);

  // Clear wins over load; the arbiter never asserts both in one cycle.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      vld  <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (ld) begin
      vld  <= 1'b1;
      addr <= ld_addr;
      data <= ld_data;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between the
// writeback stage (priority, zero latency) and the mult/div unit (valid/ready).
// One mult/div result is parked; after STARVE_LIMIT blocked cycles a one-cycle
// pipeline stall forces it out.
//
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   wb_we, wb_addr, wb_data      : writeback write request
//   md_valid, md_addr, md_data   : mult/div result (md_ready handshake)
//   md_ready                     : result accepted this cycle
//   rf_we, rf_addr, rf_data      : register-file write port
//   pipe_stall                   : freeze pipeline; writeback is replayed next cycle
//   md_pending, md_pending_addr  : parked result present / its destination (0 if none)
//
// Build option: define REGARB_WAW_SQUASH_EN to drop a parked result when the
// writeback stage writes the same register while it is parked.
module regfile_write_arbiter
  import regarb_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_addr,
  input  logic [WIDTH-1:0]  md_data,
  output logic              md_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [WIDTH-1:0]  rf_data,
  output logic              pipe_stall,
  output logic              md_pending,
  output logic [ADDR_W-1:0] md_pending_addr
);

  localparam logic [ADDR_W-1:0] ZR       = ADDR_W'(ZERO_REG);
  localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(STARVE_LIMIT - 1);

  regarb_state_e     state, state_n;
  logic [WAIT_W-1:0] wait_cnt, wait_n;
  logic              buf_ld, buf_clr, buf_vld;
  logic [ADDR_W-1:0] buf_addr;
  logic [WIDTH-1:0]  buf_data;
  logic              wb_eff;

  assign wb_eff = wb_we && (wb_addr != ZR);

  regarb_hold_buf #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_hold (
    .clock   (clock),
    .reset   (reset),
    .clr     (buf_clr),
    .ld      (buf_ld),
    .ld_addr (md_addr),
    .ld_data (md_data),
    .vld     (buf_vld),
    .addr    (buf_addr),
    .data    (buf_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= EMPTY;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
    end
  end

  always_comb begin
    state_n    = state;
    wait_n     = wait_cnt;
    buf_ld     = 1'b0;
    buf_clr    = 1'b0;
    md_ready   = 1'b0;
    pipe_stall = 1'b0;
    rf_we      = wb_eff;
    rf_addr    = wb_addr;
    rf_data    = wb_data;
    case (state)
      EMPTY: begin
        md_ready = 1'b1;
        // A result for r0 is accepted and silently dropped.
        if (md_valid && (md_addr != ZR)) begin
          buf_ld  = 1'b1;
          wait_n  = '0;
          state_n = HELD;
        end
      end
      HELD: begin
        if (!wb_eff) begin
          rf_we   = 1'b1;
          rf_addr = buf_addr;
          rf_data = buf_data;
          buf_clr = 1'b1;
          wait_n  = '0;
          state_n = EMPTY;
        end
`ifdef REGARB_WAW_SQUASH_EN
        // Younger writeback overwrites the same register: parked value is stale.
        else if (wb_addr == buf_addr) begin
          buf_clr = 1'b1;
          wait_n  = '0;
          state_n = EMPTY;
        end
`endif
        else if (wait_cnt == WAIT_TOP) begin
          state_n = FORCE;
        end else begin
          wait_n = wait_cnt + WAIT_W'(1);
        end
      end
      FORCE: begin
        // Writeback is frozen and replayed next cycle, so the port is ours.
        pipe_stall = 1'b1;
        rf_we      = 1'b1;
        rf_addr    = buf_addr;
        rf_data    = buf_data;
        buf_clr    = 1'b1;
        wait_n     = '0;
        state_n    = EMPTY;
      end
      default: begin
        state_n = EMPTY;
        wait_n  = '0;
      end
    endcase
    if (reset) begin
      md_ready   = 1'b0;
      rf_we      = 1'b0;
      pipe_stall = 1'b0;
    end
  end

  assign md_pending      = buf_vld && !reset;
  assign md_pending_addr = md_pending ? buf_addr : ZR;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int W     = 32;
  localparam int AW    = 5;
  localparam int LIMIT = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wb_we = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [W-1:0]  wb_data = '0;
  logic          md_valid = 1'b0;
  logic [AW-1:0] md_addr = '0;
  logic [W-1:0]  md_data = '0;
  logic          md_ready, rf_we, pipe_stall, md_pending;
  logic [AW-1:0] rf_addr, md_pending_addr;
  logic [W-1:0]  rf_data;

  int tests = 0;
  int fails = 0;

  regfile_write_arbiter #(.WIDTH(W), .ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data),
    .md_ready(md_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .pipe_stall(pipe_stall),
    .md_pending(md_pending), .md_pending_addr(md_pending_addr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a parked result with its acceptance cycle and the number
  // of cycles it has been blocked by writeback. Once it has been blocked LIMIT
  // times, the next cycle must be a stall that writes it.
  bit            m_pend = 0;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_data;
  int            m_blk = 0;
  int            m_acc = 0;
  int            cyc = 0;
  bit            m_last_stall = 0;
  bit            m_last_ready = 0;
  bit            squash_en;

  initial begin
`ifdef REGARB_WAW_SQUASH_EN
    squash_en = 1;
`else
    squash_en = 0;
`endif
  end

  always @(negedge clock) begin
    bit            wbe, e_stall, e_ready, e_we, e_pend, drained;
    logic [AW-1:0] e_addr, e_paddr;
    logic [W-1:0]  e_data;
    cyc++;
    wbe = wb_we && (wb_addr != 0);
    e_stall = 0; e_ready = 0; e_we = 0; e_pend = 0; drained = 0;
    e_addr = wb_addr; e_data = wb_data; e_paddr = 0;
    if (reset) begin
      // all outputs quiet
    end else if (m_pend && m_blk == LIMIT) begin
      e_stall = 1; e_we = 1; e_addr = m_addr; e_data = m_data;
      e_pend = 1; e_paddr = m_addr; drained = 1;
    end else if (m_pend) begin
      e_pend = 1; e_paddr = m_addr; e_we = 1;
      if (!wbe) begin
        e_addr = m_addr; e_data = m_data; drained = 1;
      end
    end else begin
      e_ready = 1; e_we = wbe;
    end

    chk("md_ready", md_ready, e_ready);
    chk("rf_we", rf_we, e_we);
    chk("pipe_stall", pipe_stall, e_stall);
    chk("md_pending", md_pending, e_pend);
    chk("md_pending_addr", md_pending_addr, e_paddr);
    if (e_we) begin
      chk("rf_addr", rf_addr, e_addr);
      chk("rf_data", rf_data, e_data);
    end
    if (drained) begin
      chk("latency_min", (cyc - m_acc) >= 1, 1);
      chk("latency_max", (cyc - m_acc) <= LIMIT + 1, 1);
    end

    if (reset) begin
      m_pend = 0; m_blk = 0;
    end else if (drained) begin
      m_pend = 0;
    end else if (m_pend) begin
      if (squash_en && wb_addr == m_addr) m_pend = 0;
      else m_blk++;
    end else if (md_valid && md_addr != 0) begin
      m_pend = 1; m_addr = md_addr; m_data = md_data; m_blk = 0; m_acc = cyc;
    end
    m_last_stall = e_stall;
    m_last_ready = e_ready;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_addr = 0; wb_data = 0;
    md_valid = 0; md_addr = 0; md_data = 0;
  endtask

  task automatic do_reset();
    step(); reset = 1; idle_inputs();
    step();
    step(); reset = 0;
  endtask

  initial begin
    // reset state
    step(); step();
    @(negedge clock);
    chk("rst_md_ready", md_ready, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_pending", md_pending, 0);
    step(); reset = 0;

    // idle pipeline: accept then drain next cycle
    step(); md_valid = 1; md_addr = 7; md_data = 32'hDEADBEEF;
    @(negedge clock); chk("idle_c0_ready", md_ready, 1);
    step(); md_valid = 0;
    @(negedge clock);
    chk("idle_c1_we", rf_we, 1);
    chk("idle_c1_addr", rf_addr, 7);
    chk("idle_c1_data", rf_data, 32'hDEADBEEF);
    step();
    @(negedge clock); chk("idle_c2_ready", md_ready, 1);

    // busy pipeline: forced stall on cycle LIMIT+1
    step(); md_valid = 1; md_addr = 9; md_data = 32'h99; wb_we = 1; wb_addr = 3; wb_data = 32'h33;
    @(negedge clock); chk("busy_c0_addr", rf_addr, 3);
    for (int c = 1; c <= 4; c++) begin
      step(); md_valid = 0;
      @(negedge clock);
      chk("busy_wb_addr", rf_addr, 3);
      chk("busy_no_stall", pipe_stall, 0);
    end
    step();
    @(negedge clock);
    chk("busy_c5_stall", pipe_stall, 1);
    chk("busy_c5_addr", rf_addr, 9);
    chk("busy_c5_data", rf_data, 32'h99);
    step();
    @(negedge clock);
    chk("busy_c6_addr", rf_addr, 3);
    chk("busy_c6_stall", pipe_stall, 0);

    // register 0
    step(); wb_addr = 0;
    @(negedge clock); chk("r0_wb_we", rf_we, 0);
    step(); wb_we = 0; md_valid = 1; md_addr = 0; md_data = 32'h5;
    @(negedge clock); chk("r0_md_ready", md_ready, 1);
    step(); md_valid = 0;
    @(negedge clock);
    chk("r0_md_pending", md_pending, 0);
    chk("r0_md_we", rf_we, 0);

    // reset while a result is parked
    step(); md_valid = 1; md_addr = 12; md_data = 32'hC; wb_we = 1; wb_addr = 3;
    step(); md_valid = 0;
    @(negedge clock); chk("rh_pending_addr", md_pending_addr, 12);
    step(); reset = 1;
    @(negedge clock); chk("rh_rst_pending", md_pending, 0);
    step(); reset = 0; wb_we = 0;
    @(negedge clock);
    chk("rh_ready", md_ready, 1);
    chk("rh_no_write", rf_we, 0);

    // same-register writeback while parked
    step(); md_valid = 1; md_addr = 5; md_data = 32'h11;
    step(); md_valid = 0; wb_we = 1; wb_addr = 5; wb_data = 32'h22;
    @(negedge clock); chk("waw_c1_data", rf_data, 32'h22);
    step(); wb_we = 0;
    @(negedge clock);
    chk("waw_c2_stall", pipe_stall, 0);
`ifdef REGARB_WAW_SQUASH_EN
    chk("waw_c2_we", rf_we, 0);
    chk("waw_c2_ready", md_ready, 1);
`else
    chk("waw_c2_we", rf_we, 1);
    chk("waw_c2_data", rf_data, 32'h11);
`endif

    // randomized traffic honoring the stall-replay and valid/ready contracts
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      bit hold_md;
      hold_md = md_valid && !m_last_ready && !reset;
      step();
      reset = ($urandom_range(0, 299) == 0);
      if (!m_last_stall) begin
        wb_we   = ($urandom_range(0, 99) < 70);
        wb_addr = AW'($urandom_range(0, 7));
        wb_data = $urandom;
      end
      if (!hold_md) begin
        md_valid = ($urandom_range(0, 99) < 40);
        md_addr  = AW'($urandom_range(0, 7));
        md_data  = $urandom;
      end
    end
    step(); idle_inputs();
    step();
    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two sources:
  - the pipeline writeback stage, which cannot be back-pressured except by stall;
  - the multi-cycle mult/div unit, which uses a valid/ready handshake.
- The writeback stage has priority. One mult/div result is parked in a holding buffer until the port is free.
- A starvation guard forces a one-cycle pipeline stall so a parked result is always written.
- Sits between the writeback stage, the mult/div unit and the register file write port.

Parameters:
WIDTH, 32, data width of register-file entries
ADDR_W, 5, register address width
STARVE_LIMIT, 4, blocked cycles a parked result tolerates before a forced stall; legal range 1..255

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
wb_we  in  1  writeback write request
wb_addr  in  ADDR_W  writeback destination register
wb_data  in  WIDTH  writeback data
md_valid  in  1  mult/div result valid
md_addr  in  ADDR_W  mult/div destination register
md_data  in  WIDTH  mult/div result
md_ready  out  1  arbiter can accept a mult/div result this cycle
rf_we  out  1  register-file write enable
rf_addr  out  ADDR_W  register-file write address
rf_data  out  WIDTH  register-file write data
pipe_stall  out  1  freeze pipeline for this cycle; writeback inputs must be held stable
md_pending  out  1  holding buffer occupied
md_pending_addr  out  ADDR_W  destination of the parked result; 0 when empty

Behaviour:
- Interface: one clock `clock`; `reset` is synchronous and active-high.
- wb_eff = wb_we & (wb_addr != 0). Writes to register 0 never reach rf_we.
- State register with states EMPTY, HELD, FORCE. Also an 8-bit wait_cnt and a holding buffer {addr, data}.
- Reset:
  - state=EMPTY, wait_cnt=0, buffer cleared.
  - While reset is high: md_ready=0, rf_we=0, pipe_stall=0, md_pending=0.
  - Reset in HELD or FORCE discards the parked result.
- Outputs are combinational from the current state and current-cycle inputs. Writeback has zero added latency.
- EMPTY:
  - md_ready=1. rf_* = wb_* with rf_we=wb_eff.
  - md_valid & md_addr!=0: capture into buffer, wait_cnt=0, next state HELD.
  - md_valid & md_addr==0: accept and discard; stay EMPTY.
- HELD:
  - md_ready=0; md_pending=1.
  - If !wb_eff: rf_* = buffer, rf_we=1, next state EMPTY. The next acceptance happens in the following cycle; there is no same-cycle refill.
  - If wb_eff: rf_* = wb_*. If wait_cnt==STARVE_LIMIT-1, next state FORCE; otherwise wait_cnt+1.
- FORCE:
  - pipe_stall=1, md_ready=0.
  - rf_* = buffer, rf_we=1. Writeback inputs are ignored this cycle and replayed by the stalled pipeline in the next cycle.
  - Next state EMPTY, wait_cnt=0.
- Latency:
  - An accepted result is written no earlier than 1 cycle after acceptance.
  - It is written no later than STARVE_LIMIT+1 cycles after acceptance.
- pipe_stall is asserted only in FORCE, for exactly one cycle per forced drain.
- Ordering: the hazard unit uses md_pending and md_pending_addr to keep younger instructions from writing a parked address, unless the optional feature below is enabled.

Optional Feature:
- Macro: REGARB_WAW_SQUASH_EN
- Enabled: in HELD, a cycle with wb_eff and wb_addr==buffer addr writes the writeback data and discards the parked result.
  - The parked result is stale.
  - Next state EMPTY, wait_cnt=0. FORCE is not entered.
- Disabled: no address comparison is made. The parked result is written by the normal rules even if it is stale.

Decomposition:
- Package regarb_pkg holds:
  - the state encoding (EMPTY=2'd0, HELD=2'd1, FORCE=2'd2);
  - ZERO_REG constant;
  - wait counter width (8).
- One sub-module, regarb_hold_buf: enable-loaded {addr, data} register with a synchronous clear and a valid bit.

Test Plan:
- Idle pipeline:
  - Stimulus: md_valid=1, md_addr=7, md_data=0xDEADBEEF in cycle 0, wb_we=0.
  - Response: md_ready=1 in cycle 0; rf_we=1, rf_addr=7, rf_data=0xDEADBEEF in cycle 1; md_ready=1 in cycle 2.
- Busy pipeline:
  - Stimulus: STARVE_LIMIT=4, md accepted to r9, wb_we=1 continuously to r3.
  - Response: cycles 1-4 write r3; cycle 5 pipe_stall=1 and rf writes r9; cycle 6 writes r3 again.
- Register 0:
  - Stimulus: wb_we=1, wb_addr=0.
  - Response: rf_we=0.
  - Stimulus: md_valid=1, md_addr=0.
  - Response: accepted, md_pending stays 0, no write.
- Reset in HELD:
  - Stimulus: result parked at r12, reset asserted for 1 cycle.
  - Response: md_pending=0 and no r12 write afterward; md_ready=1 in the first cycle after reset.
- REGARB_WAW_SQUASH_EN defined:
  - Stimulus: parked r5=0x11, then wb writes r5=0x22.
  - Response: only 0x22 is written; no forced stall; state returns to EMPTY.
- REGARB_WAW_SQUASH_EN undefined, same stimulus:
  - Response: 0x22 is written, then 0x11 is written in the first wb-idle cycle or the FORCE cycle.
